// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: DMCtrl encodings, the positions of
// the size and unsigned fields inside DMCtrl, and a helper that decodes the
// access size. Codes 011, 110 and 111 decode as word accesses.
package dmem_pkg;

    // DMCtrl encodings (loads and stores share them; bit 2 matters only on loads)
    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    // Field positions inside DMCtrl
    localparam int DM_SIZE_LSB     = 0;
    localparam int DM_SIZE_MSB     = 1;
    localparam int DM_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } dm_size_e;

    // Size bit 1 set means word regardless of bit 0
    function automatic dm_size_e dm_size(input logic [2:0] ctrl);
        if (ctrl[DM_SIZE_MSB]) begin
            return SZ_WORD;
        end else if (ctrl[DM_SIZE_LSB]) begin
            return SZ_HALF;
        end else begin
            return SZ_BYTE;
        end
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load path of the data memory: picks the byte or halfword lane out of the
// addressed word and sign- or zero-extends it to 32 bits. Purely combinational.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dmctrl,
    output logic [31:0] data_rd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    // Lane select followed by extension according to the access size
    always_comb begin
        byte_sel = raw_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        sign_ext = ~dmctrl[DM_UNSIGNED_BIT];
        data_rd  = raw_word;
        case (dm_size(dmctrl))
            SZ_BYTE: data_rd = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_rd = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data_rd = raw_word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the RV32I MEM stage.
// Stores commit on the rising clock edge; loads are combinational.
// There is no handshake: every cycle is accepted, no stall is ever raised.
// Optional feature macro DMEM_RESET_CLEAR_EN: when defined, rst_n low
// asynchronously clears every word; otherwise rst_n only inhibits stores and
// the array has no reset branch so it can map onto a RAM.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [0:DEPTH-1];
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic          unused_addr_hi;

    // Address bits above the array simply wrap
    assign word_idx       = Address[AW+1:2];
    assign lane           = Address[1:0];
    assign unused_addr_hi = ^Address[31:AW+2];

    // Byte enables and store data replicated onto every lane it may land in
    always_comb begin
        byte_en = 4'b1111;
        wr_data = DataWr;
        case (dm_size(DMCtrl))
            SZ_BYTE: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{DataWr[7:0]}};
            end
            SZ_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{DataWr[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = DataWr;
            end
        endcase
    end

`ifdef DMEM_RESET_CLEAR_EN
    // Array with asynchronous clear; stores are blocked while reset is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (DMWr) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end
`else
    // Plain RAM write port; rst_n acts only as a store inhibit
    always_ff @(posedge clk) begin
        if (rst_n && DMWr) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end
`endif

    assign rd_word = mem[word_idx];

    dmem_load_ext u_load_ext (
        .raw_word (rd_word),
        .addr_lo  (lane),
        .dmctrl   (DMCtrl),
        .data_rd  (DataRd)
    );

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory (DEPTH = 256). Expected load results
// are pushed onto exp_q when a load is driven and popped when DataRd is
// sampled. A byte-array reference model backs the randomized section.
module tb_data_memory;
    import dmem_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;

    always #5 clk = ~clk;

    data_memory #(.DEPTH(256)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Address (Address),
        .DataWr  (DataWr),
        .DMWr    (DMWr),
        .DMCtrl  (DMCtrl),
        .DataRd  (DataRd)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mb [0:1023];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: byte-level store (address wraps at 1 KiB)
    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        int b;
        b = int'(a[9:0]);
        if (c[1]) begin
            b = b & ~3;
            mb[b] = d[7:0]; mb[b+1] = d[15:8]; mb[b+2] = d[23:16]; mb[b+3] = d[31:24];
        end else if (c[0]) begin
            b = b & ~1;
            mb[b] = d[7:0]; mb[b+1] = d[15:8];
        end else begin
            mb[b] = d[7:0];
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
        int b;
        logic [15:0] h;
        b = int'(a[9:0]);
        if (c[1]) begin
            b = b & ~3;
            return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
        end else if (c[0]) begin
            b = b & ~1;
            h = {mb[b+1], mb[b]};
            return c[2] ? {16'h0, h} : {{16{h[15]}}, h};
        end else begin
            return c[2] ? {24'h0, mb[b]} : {{24{mb[b][7]}}, mb[b]};
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        Address = a; DataWr = d; DMCtrl = c; DMWr = 1'b1;
        @(posedge clk);
        #1;
        DMWr = 1'b0;
        if (rst_n) model_store(a, d, c);
    endtask

    task automatic drive_load(input logic [31:0] a, input logic [2:0] c, input logic [31:0] e);
        @(negedge clk);
        Address = a; DMCtrl = c; DMWr = 1'b0;
        exp_q.push_back(e);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [31:0] e, got;
        logic [31:0] ra [4];
        logic [2:0]  rc [4];
        rst_n = 1'b0; DMWr = 1'b0; Address = '0; DataWr = '0; DMCtrl = DM_W;
        repeat (2) @(negedge clk);
`ifdef DMEM_RESET_CLEAR_EN
        ra = '{32'h0, 32'h3FC, 32'h155, 32'h200};
        rc = '{DM_B, DM_HU, DM_H, DM_W};
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive_load(ra[i], rc[i], 32'h0);
            got = DataRd; e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_clear[%0d]: addr=%h got %h expected %h", i, ra[i], got, e);
            end
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_store(32'h0, 32'h0102_0304, DM_W);
        // store attempted while reset is held low must be ignored
        @(negedge clk);
        rst_n = 1'b0;
        drive_store(32'h0, 32'hDEAD_BEEF, DM_W);
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < 4; i++) begin mb[i] = 8'h00; end
        e = 32'h0;
`else
        e = 32'h0102_0304;
`endif
        drive_load(32'h0, DM_W, e);
        got = DataRd; e = exp_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_inhibit: got %h expected %h", got, e);
        end
        // release reset away from any clock edge
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] e, got;
        @(negedge clk);
        Address = 32'h0; DataWr = 32'hAABB_CCDD; DMCtrl = DM_W; DMWr = 1'b1;
`ifdef DMEM_RESET_CLEAR_EN
        exp_q.push_back(32'h0);
`else
        exp_q.push_back(32'h0102_0304);
`endif
        #1;
        got = DataRd; e = exp_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL word_before_edge: got %h expected %h", got, e);
        end
        exp_q.push_back(32'hAABB_CCDD);
        @(posedge clk);
        #1;
        got = DataRd; e = exp_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL word_after_edge: got %h expected %h", got, e);
        end
        DMWr = 1'b0;
        model_store(32'h0, 32'hAABB_CCDD, DM_W);
    endtask

    task automatic test_lanes;
        logic [31:0] e, got;
        logic [31:0] la [12];
        logic [2:0]  lc [12];
        logic [31:0] le [12];
        la = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h2, 32'h2, 32'h0, 32'h0, 32'h3, 32'h0, 32'h3, 32'h0};
        lc = '{DM_W, DM_B, DM_BU, DM_W, DM_H, DM_HU, DM_H, DM_W, DM_BU, DM_B, DM_B, 3'b111};
        le = '{32'hAABB_EEDD, 32'hFFFF_FFEE, 32'h0000_00EE,
               32'hFF55_EEDD, 32'hFFFF_FF55, 32'h0000_FF55, 32'hFFFF_EEDD,
               32'h1255_EEDD, 32'h0000_0012, 32'hFFFF_FFDD, 32'h0000_0012, 32'h1255_EEDD};
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin @(negedge clk); drive_store(32'h1, 32'hFFFF_FFEE, DM_B); end
            if (i == 3) begin @(negedge clk); drive_store(32'h2, 32'h1234_FF55, DM_H); end
            if (i == 7) begin @(negedge clk); drive_store(32'h3, 32'h0000_0012, DM_BU); end
            drive_load(la[i], lc[i], le[i]);
            got = DataRd; e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lanes[%0d]: addr=%h ctrl=%b got %h expected %h", i, la[i], lc[i], got, e);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] e, got;
        logic [31:0] la [3];
        logic [31:0] le [3];
        @(negedge clk);
        drive_store(32'h0000_0400, 32'h1122_3344, DM_W);
        drive_store(32'hFFFF_F404, 32'h5566_7788, DM_W);
        la = '{32'h0, 32'h4, 32'h0000_0404};
        le = '{32'h1122_3344, 32'h5566_7788, 32'h5566_7788};
        for (int i = 0; i < 3; i++) begin
            drive_load(la[i], DM_W, le[i]);
            got = DataRd; e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wrap[%0d]: addr=%h got %h expected %h", i, la[i], got, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e, got;
        logic [31:0] la [5];
        logic [2:0]  lc [5];
        logic [31:0] le [5];
        @(negedge clk);
        drive_store(32'h20, 32'h0000_0011, DM_B);
        drive_store(32'h21, 32'h0000_0022, DM_B);
        drive_store(32'h22, 32'h0000_0033, DM_BU);
        drive_store(32'h23, 32'h0000_0044, DM_B);
        drive_load(32'h20, DM_W, 32'h4433_2211);
        got = DataRd; e = exp_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL b2b_bytes: got %h expected %h", got, e);
        end
        @(negedge clk);
        drive_store(32'h21, 32'h0000_BEEF, DM_HU);
        drive_store(32'h27, 32'hCAFE_F00D, 3'b110);
        la = '{32'h20, 32'h24, 32'h26, 32'h27, 32'h25};
        lc = '{DM_W, 3'b111, DM_BU, DM_HU, 3'b011};
        le = '{32'h4433_BEEF, 32'hCAFE_F00D, 32'h0000_00FE, 32'h0000_CAFE, 32'hCAFE_F00D};
        for (int i = 0; i < 5; i++) begin
            drive_load(la[i], lc[i], le[i]);
            got = DataRd; e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: addr=%h ctrl=%b got %h expected %h", i, la[i], lc[i], got, e);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] e, got, a, d;
        logic [2:0]  c;
        @(negedge clk);
        for (int w = 0; w < 8; w++) drive_store(32'h100 + 32'(4 * w), $urandom, DM_W);
        for (int i = 0; i < 60; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 31));
            a = a | ($urandom & 32'hFFFF_FC00);
            d = $urandom;
            c = 3'($urandom_range(0, 7));
            @(negedge clk);
            drive_store(a, d, c);
            a = 32'h100 + 32'($urandom_range(0, 31));
            c = 3'($urandom_range(0, 7));
            drive_load(a, c, model_load(a, c));
            got = DataRd; e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL random[%0d]: addr=%h ctrl=%b got %h expected %h", i, a, c, got, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_wrap();
        test_back_to_back();
        test_random();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

- Byte-addressable data memory for the RV32I core's MEM stage.
- Supports RV32I loads and stores: `LB`, `LH`, `LW`, `LBU`, `LHU`, `SB`, `SH`, `SW`.
- Writes are synchronous. Reads are combinational, with lane selection and sign/zero extension.
- Storage is little-endian: byte lane k of a word is at byte address 4·n+k.

## Interface
Parameters:
- `DEPTH`, default 256: number of 32-bit words. Must be a power of two.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock; stores commit on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `Address` input 32: byte address. Bits [log2(DEPTH)+1:2] select the word; [1:0] select the lane; higher bits are ignored, so the address wraps.
- `DataWr` input 32: store data, taken from its low bits.
- `DMWr` input 1: store enable.
- `DMCtrl` input 3: access type. Bit 2 selects unsigned; bits [1:0] select size: 00 byte, 01 half, 1x word.
- `DataRd` output 32: load result, combinational.

## Operation
- Encodings: 000 `LB`/`SB`, 001 `LH`/`SH`, 010 `LW`/`SW`, 100 `LBU`, 101 `LHU`. 011, 110 and 111 behave as word.
- Byte store: `DataWr[7:0]` goes to lane `Address[1:0]`. Other lanes are unchanged.
- Half store: `DataWr[15:0]` goes to lanes {1,0} if `Address[1]`=0, else lanes {3,2}. `Address[0]` is ignored; no misalignment trap.
- Word store: the full word is written. `Address[1:0]` is ignored.
- Bit 2 is ignored on stores.
- Byte load: returns lane `Address[1:0]`. Sign-extended if bit2=0, zero-extended if bit2=1.
- Half load: returns the half selected by `Address[1]`, with the same extension rule.
- Word load: returns the whole word.
- Loads are always active and independent of `DMWr`.

## Timing
- `DataRd` is purely combinational from `Address`, `DMCtrl` and the array. No load latency.
- A store commits at the rising `clk` when `DMWr`=1 and `rst_n`=1.
- A load during a store cycle shows the old contents until the edge, then the new contents in the same cycle.
- While `rst_n`=0, stores are ignored.
- Reset values:
  - With `DMEM_RESET_CLEAR_EN`: asserting `rst_n` clears every word to 0, so `DataRd` reads 0.
  - Without it: no reset effect on the array, and `DataRd` reflects the current contents.
- Deasserting reset mid-cycle has no side effect; the next rising edge with `DMWr`=1 stores normally.
- There are no handshakes and no stalls.

## Configuration
- `DMEM_RESET_CLEAR_EN` defined: `rst_n` asynchronously zeroes all `DEPTH` words.
- Not defined:
  - `rst_n` is only a store inhibit.
  - Initial contents are undefined (X in simulation).
  - The array is written only from a clocked process with no reset branch, so it can be inferred as RAM.

## Structure
- Package `dmem_pkg`:
  - `DMCtrl` constants: `DM_B`=000, `DM_H`=001, `DM_W`=010, `DM_BU`=100, `DM_HU`=101.
  - Size field positions.
- Sub-module `dmem_load_ext`: combinational lane select plus sign/zero extension.
  - Inputs: raw word, `Address[1:0]`, `DMCtrl`.
  - Output: `DataRd`.
- Top level holds the array, the byte-enable generation and the store data replication.

## Test plan
- Reset with `DMEM_RESET_CLEAR_EN` -> `DataRd`=0 at any address, in any mode.
- `SW` 0xAABBCCDD at 0x0, then `LW` 0x0 -> 0xAABBCCDD. `DataRd` changes only after the edge.
- `SB` 0xEE at 0x1 -> word reads 0xAABBEEDD; `LB` 0x1 -> 0xFFFFFFEE; `LBU` 0x1 -> 0x000000EE.
- `SH` 0xFF55 at 0x2 -> word reads 0xFF55EEDD; `LH` 0x2 -> 0xFFFFFF55; `LHU` 0x2 -> 0x0000FF55; `LH` 0x0 -> 0xFFFFEEDD.
- `SB` 0x12 at 0x3 -> word reads 0x1255EEDD; `LBU` 0x3 -> 0x00000012; `LB` 0x0 -> 0xFFFFFFDD.
- Wrap and inhibit cases:
  - With `DEPTH`=256, `SW` 0x11223344 at 0x400 -> `LW` 0x0 returns 0x11223344.
  - `DMWr`=1 with `rst_n`=0 -> no change.
